alu_share_ctrl: RTL and testbench

//  Shares the single 16-bit ALU between two requesters, e.g. the EX-stage issue and
//  a PADSUB/RED helper. Round-robin arbitration; one op in flight. Registers the ALU

---
 rtl/alu_share_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one external ALU between two requesters.
// Round-robin grant, one operation in flight (IDLE -> EXEC -> RESP).
// The ALU inputs, the result and the captured flags are registered. Each result
// is returned over a valid/ready handshake. This block owns the architectural
// {Z,V,N} flag register and updates it when a response is accepted.
// Optional feature: define ALU_ERR_STICKY_EN to build the sticky error bit.
// Without it, err_sticky is tied low and err_clr is ignored.
module alu_share_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned OPW      = 3,
    parameter logic [2:0]  FLAG_RST = 3'b000
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,

    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_err,
    input  logic [2:0]       alu_flags,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,

    output logic [2:0]       flags,
    output logic             err_sticky,
    input  logic             err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_XOR    = 3'd2,
        OP_RED    = 3'd3,
        OP_SLL    = 3'd4,
        OP_SRA    = 3'd5,
        OP_ROR    = 3'd6,
        OP_PADSUB = 3'd7
    } opcode_e;

    state_e           state_q;
    logic             ptr_q;        // side that wins when both requesters are valid
    logic [WIDTH-1:0] alu_in1_q;
    logic [WIDTH-1:0] alu_in2_q;
    logic [OPW-1:0]   alu_op_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_err_q;
    logic [2:0]       rsp_flags_q;  // ALU flags captured with the result
    logic [2:0]       flags_q;
    logic [2:0]       flags_d;

    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic             rsp_hs;

    // Round-robin grant: a lone valid requester wins; ties go to ptr_q.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = ptr_q;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ptr_q;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // The ready outputs are forced low while reset is asserted.
    assign accept     = ~rst & (state_q == ST_IDLE) & grant_vld;
    assign req0_ready = accept & ~grant_id;
    assign req1_ready = accept &  grant_id;
    assign rsp_hs     = rsp_valid_q & rsp_ready;

    // Flag update on response accept, masked by the opcode that produced it.
    always_comb begin
        flags_d = flags_q;
        if (rsp_hs) begin
            case (opcode_e'(alu_op_q[2:0]))
                OP_ADD, OP_SUB: flags_d = rsp_flags_q;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d[2] = rsp_flags_q[2];
                default: flags_d = flags_q;
            endcase
        end
    end

    // Control FSM with registered ALU operands, response and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_flags_q <= '0;
            flags_q     <= FLAG_RST;
        end else begin
            flags_q <= flags_d;
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        alu_in1_q <= grant_id ? req1_a  : req0_a;
                        alu_in2_q <= grant_id ? req1_b  : req0_b;
                        alu_op_q  <= grant_id ? req1_op : req0_op;
                        rsp_id_q  <= grant_id;
                        ptr_q     <= ~grant_id;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_err_q   <= alu_err;
                    rsp_flags_q <= alu_flags;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_ERR_STICKY_EN
    logic sticky_q;
    logic sticky_d;

    // Sticky error: set on an accepted error response (set beats clear).
    always_comb begin
        sticky_d = sticky_q;
        if (rsp_hs && rsp_err_q) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Sticky error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign err_sticky = sticky_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err_sticky     = 1'b0;
`endif

    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl. It provides a behavioural ALU, a transaction-level
// reference model that is compared every cycle, and directed scenarios with
// literal expectations.
module tb_alu_share_ctrl;

    localparam logic [2:0] FLAG_RST = 3'b000;
`ifdef ALU_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op, alu_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] alu_in1, alu_in2, alu_out, rsp_data;
    logic        alu_err, rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [2:0]  alu_flags, flags;
    logic        err_sticky, err_clr;
    logic        ov_en;
    logic [2:0]  ov_flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_ctrl #(.WIDTH(16), .OPW(3), .FLAG_RST(FLAG_RST)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_err(alu_err), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flags(flags), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    // ALU behaviour: returns {Z,V,N, err, result}
    function automatic logic [19:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            3'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
            3'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
            3'd2: r = a ^ b;
            3'd3: r = {8'h00, a[15:8]} + {8'h00, a[7:0]};
            3'd4: r = a << b[3:0];
            3'd5: r = $signed(a) >>> b[3:0];
            3'd6: r = (a >> b[3:0]) | (a << (5'd16 - {1'b0, b[3:0]}));
            default: r = {a[15:8] - b[15:8], a[7:0] - b[7:0]};
        endcase
        return {(r == 16'h0000), v, r[15], v, r};
    endfunction

    function automatic logic [19:0] with_ov(input logic [19:0] r);
        return ov_en ? {ov_flags, r[16:0]} : r;
    endfunction

    always_comb begin
        logic [19:0] t;
        t         = with_ov(alu_f(alu_op, alu_in1, alu_in2));
        alu_out   = t[15:0];
        alu_err   = t[16];
        alu_flags = t[19:17];
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        id;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } txn_t;

    txn_t        m_txn;
    logic [19:0] m_res;
    logic        m_busy;
    int          m_age;     // cycles since the accept edge while busy
    logic        m_ptr;
    logic [2:0]  m_flags;
    logic        m_sticky;

    function automatic int pick(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return 3'b111;
            3'd2, 3'd4, 3'd5, 3'd6: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_txn    <= '0;
            m_res    <= '0;
            m_busy   <= 1'b0;
            m_age    <= 0;
            m_ptr    <= 1'b0;
            m_flags  <= FLAG_RST;
            m_sticky <= 1'b0;
        end else begin
            if (!m_busy) begin
                if (pick(req0_valid, req1_valid, m_ptr) == 0) begin
                    m_txn  <= '{id: 1'b0, op: req0_op, a: req0_a, b: req0_b};
                    m_ptr  <= 1'b1;
                    m_busy <= 1'b1;
                    m_age  <= 1;
                end else if (pick(req0_valid, req1_valid, m_ptr) == 1) begin
                    m_txn  <= '{id: 1'b1, op: req1_op, a: req1_a, b: req1_b};
                    m_ptr  <= 1'b0;
                    m_busy <= 1'b1;
                    m_age  <= 1;
                end
            end else if (m_age == 1) begin
                m_res <= with_ov(alu_f(m_txn.op, m_txn.a, m_txn.b));
                m_age <= 2;
            end else if (rsp_ready) begin
                m_flags <= (m_flags & ~flag_mask(m_txn.op)) | (m_res[19:17] & flag_mask(m_txn.op));
                m_busy  <= 1'b0;
            end
`ifdef ALU_ERR_STICKY_EN
            if (m_busy && m_age >= 2 && rsp_ready && m_res[16]) m_sticky <= 1'b1;
            else if (err_clr) m_sticky <= 1'b0;
`endif
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        int   g;
        logic ev;
        g  = pick(req0_valid, req1_valid, m_ptr);
        ev = m_busy && (m_age >= 2);
        chk("m_req0_ready", req0_ready, !rst && !m_busy && g == 0);
        chk("m_req1_ready", req1_ready, !rst && !m_busy && g == 1);
        chk("m_rsp_valid", rsp_valid, ev);
        chk("m_alu_in1", alu_in1, m_txn.a);
        chk("m_alu_in2", alu_in2, m_txn.b);
        chk("m_alu_op", alu_op, m_txn.op);
        chk("m_flags", flags, m_flags);
        chk("m_err_sticky", err_sticky, m_sticky);
        if (ev) begin
            chk("m_rsp_id", rsp_id, m_txn.id);
            chk("m_rsp_data", rsp_data, m_res[15:0]);
            chk("m_rsp_err", rsp_err, m_res[16]);
        end
    end

    // ---------------- requester agents ----------------
    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } op_t;

    op_t q0[$];
    op_t q1[$];

    function automatic op_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        return '{op: op, a: a, b: b};
    endfunction

    initial begin
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        forever begin
            logic a0, a1;
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0 || a1) acc_cyc = cyc;
            @(posedge clk);
            #1;
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            req0_valid = (q0.size() != 0);
            if (req0_valid) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
            req1_valid = (q1.size() != 0);
            if (req1_valid) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
        end
    end

    // Waits for the next response; also checks its latency from the accept cycle.
    task automatic wait_rsp(input string name, input logic exp_id, input logic [15:0] exp_data, input logic exp_err);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (rsp_valid) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no rsp_valid within 40 cycles", name);
        end else begin
            chk({name, "_lat"}, cyc - acc_cyc, 2);
            chk({name, "_id"}, rsp_id, exp_id);
            chk({name, "_data"}, rsp_data, exp_data);
            chk({name, "_err"}, rsp_err, exp_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; rsp_ready = 1'b0; err_clr = 1'b0; ov_en = 1'b0; ov_flags = 3'b000;
        repeat (2) @(negedge clk);
        chk("rst_flags", flags, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu_in1", alu_in1, 16'h0000);
        chk("rst_sticky", err_sticky, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: overflowing ADD from req0 alone
        rsp_ready = 1'b1;
        q0.push_back(mk(3'd0, 16'h7FFF, 16'h0001));
        wait_rsp("t1", 1'b0, 16'h8000, 1'b1);
        @(negedge clk);
        chk("t1_flags", flags, 3'b011);
        chk("t1_sticky", err_sticky, STICKY);

        // 2: both valid straight out of reset, req0 wins first
        #1 rst = 1'b1;
        q0.push_back(mk(3'd2, 16'h00FF, 16'h00FF));
        q1.push_back(mk(3'd1, 16'h0005, 16'h0005));
        @(negedge clk);
        chk("t2_rst_flags", flags, 3'b000);
        @(posedge clk); #1 rst = 1'b0;
        wait_rsp("t2a", 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        chk("t2a_flags", flags, 3'b100);
        wait_rsp("t2b", 1'b1, 16'h0000, 1'b0);
        @(negedge clk);
        chk("t2b_flags", flags, 3'b100);

        // 3: force flags to 111, RED leaves them, SLL touches Z only
        ov_en = 1'b1; ov_flags = 3'b111;
        q0.push_back(mk(3'd0, 16'h0001, 16'h0001));
        wait_rsp("t3a", 1'b0, 16'h0002, 1'b0);
        @(negedge clk);
        chk("t3a_flags", flags, 3'b111);
        ov_en = 1'b0;
        q1.push_back(mk(3'd3, 16'h1234, 16'h0000));
        wait_rsp("t3b", 1'b1, 16'h0046, 1'b0);
        @(negedge clk);
        chk("t3b_flags", flags, 3'b111);
        q0.push_back(mk(3'd4, 16'h0001, 16'h0001));
        wait_rsp("t3c", 1'b0, 16'h0002, 1'b0);
        @(negedge clk);
        chk("t3c_flags", flags, 3'b011);

        // 4: consumer stalls for 5 cycles while req0 waits
        rsp_ready = 1'b0;
        q1.push_back(mk(3'd2, 16'h0F0F, 16'h0F0F));
        wait_rsp("t4a", 1'b1, 16'h0000, 1'b0);
        q0.push_back(mk(3'd0, 16'h0001, 16'h0002));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", rsp_valid, 1'b1);
            chk("t4_stall_data", rsp_data, 16'h0000);
            chk("t4_stall_r0", req0_ready, 1'b0);
            chk("t4_stall_r1", req1_ready, 1'b0);
            chk("t4_stall_flags", flags, 3'b011);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4a_flags", flags, 3'b111);
        wait_rsp("t4b", 1'b0, 16'h0003, 1'b0);
        @(negedge clk);
        chk("t4b_flags", flags, 3'b000);

        // 5: reset during EXEC; ptr points at req1 beforehand, req0 first after
        q0.push_back(mk(3'd1, 16'h0009, 16'h0003));
        for (int i = 0; i < 20 && !req0_ready; i++) @(negedge clk);
        chk("t5_accept", req0_ready, 1'b1);
        @(negedge clk);
        chk("t5_exec_in1", alu_in1, 16'h0009);
        #1 rst = 1'b1;
        #1;
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_in1", alu_in1, 16'h0000);
        chk("t5_in2", alu_in2, 16'h0000);
        chk("t5_op", alu_op, 3'd0);
        chk("t5_data", rsp_data, 16'h0000);
        chk("t5_id", rsp_id, 1'b0);
        chk("t5_err", rsp_err, 1'b0);
        chk("t5_flags", flags, FLAG_RST);
        chk("t5_sticky", err_sticky, 1'b0);
        q0.push_back(mk(3'd2, 16'h0001, 16'h0002));
        q1.push_back(mk(3'd0, 16'h0004, 16'h0004));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_rsp("t5a", 1'b0, 16'h0003, 1'b0);
        wait_rsp("t5b", 1'b1, 16'h0008, 1'b0);
        @(negedge clk);

        // 6: sticky error set / clear precedence
        q0.push_back(mk(3'd0, 16'h7FFF, 16'h0001));
        wait_rsp("t6a", 1'b0, 16'h8000, 1'b1);
        @(negedge clk);
        chk("t6_set", err_sticky, STICKY);
        q1.push_back(mk(3'd0, 16'h7FFF, 16'h7FFF));
        wait_rsp("t6b", 1'b1, 16'hFFFE, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("t6_set_wins", err_sticky, STICKY);
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("t6_clear", err_sticky, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
